// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB first, parity, stop(1).
// Deserialises the word, checks parity and the stop bit, and presents the result
// with a one-cycle data_valid strobe. All outputs are registered.
module parity_frame_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              x,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StPar,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              acc_q, acc_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

    // New bit enters at the MSB so the word ends up LSB-first aligned.
    logic [DATA_W:0]   shift_w;
    assign shift_w = {x, shift_q};

    // Next-state and next-output logic for the receive FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        acc_d        = acc_q;
        perr_d       = perr_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        unique case (state_q)
            StIdle: begin
                if (!x) begin
                    state_d = StData;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end
            end
            StData: begin
                shift_d = shift_w[DATA_W:1];
                acc_d   = acc_q ^ x;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntW'(DATA_W - 1)) begin
                    state_d = StPar;
                end
            end
            StPar: begin
                perr_d  = ((acc_q ^ x) != PARITY_ODD);
                state_d = StStop;
            end
            StStop: begin
                data_out_d   = shift_q;
                parity_err_d = perr_q;
                frame_err_d  = ~x;
                data_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and registered outputs; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            shift_q      <= '0;
            acc_q        <= 1'b0;
            perr_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            acc_q        <= acc_d;
            perr_q       <= perr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Scoreboard bench for parity_frame_rx: an 8-bit even-parity instance and a
// 5-bit odd-parity instance share clock and reset; each has its own serial line.
module tb_parity_frame_rx;

    logic       clk;
    logic       rst_n;
    logic       x8, x5;
    logic [7:0] data_out8;
    logic [4:0] data_out5;
    logic       dv8, perr8, ferr8, busy8;
    logic       dv5, perr5, ferr5, busy5;

    parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x8),
        .data_out   (data_out8),
        .data_valid (dv8),
        .parity_err (perr8),
        .frame_err  (ferr8),
        .busy       (busy8)
    );

    parity_frame_rx #(.DATA_W(5), .PARITY_ODD(1'b1)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x5),
        .data_out   (data_out5),
        .data_valid (dv5),
        .parity_err (perr5),
        .frame_err  (ferr5),
        .busy       (busy5)
    );

    typedef struct {
        logic [31:0] data;
        logic        perr;
        logic        ferr;
        int          start_cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q5[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int run8   = 0;
    int run5   = 0;
    int strobes8 = 0;
    int strobes5 = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive_bit(input int inst, input logic b);
        @(negedge clk);
        if (inst == 8) x8 = b;
        else           x5 = b;
    endtask

    // Drive one complete frame; the expectation is queued once the start bit is on the line.
    task automatic send_frame(input int inst, input int n, input logic [31:0] d,
                              input logic par, input logic stop,
                              input logic ep, input logic ef);
        exp_t e;
        drive_bit(inst, 1'b0);
        e.data      = d;
        e.perr      = ep;
        e.ferr      = ef;
        e.start_cyc = cyc + 1;
        if (inst == 8) q8.push_back(e);
        else           q5.push_back(e);
        for (int i = 0; i < n; i++) drive_bit(inst, d[i]);
        drive_bit(inst, par);
        drive_bit(inst, stop);
    endtask

    task automatic idle(input int inst, input int cycles);
        for (int i = 0; i < cycles; i++) drive_bit(inst, 1'b1);
    endtask

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            run8 = 0;
        end else if (busy8) begin
            run8++;
        end else begin
            if (dv8) begin
                strobes8++;
                if (q8.size() == 0) begin
                    check("dut8_unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = q8.pop_front();
                    check("dut8_data_out", {24'd0, data_out8}, e.data);
                    check("dut8_parity_err", {31'd0, perr8}, {31'd0, e.perr});
                    check("dut8_frame_err", {31'd0, ferr8}, {31'd0, e.ferr});
                    check("dut8_latency", cyc, e.start_cyc + 10);
                    check("dut8_busy_len", run8, 10);
                end
            end
            run8 = 0;
        end
    end

    // Monitor for the 5-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            run5 = 0;
        end else if (busy5) begin
            run5++;
        end else begin
            if (dv5) begin
                strobes5++;
                if (q5.size() == 0) begin
                    check("dut5_unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    e = q5.pop_front();
                    check("dut5_data_out", {27'd0, data_out5}, e.data);
                    check("dut5_parity_err", {31'd0, perr5}, {31'd0, e.perr});
                    check("dut5_frame_err", {31'd0, ferr5}, {31'd0, e.ferr});
                    check("dut5_latency", cyc, e.start_cyc + 7);
                    check("dut5_busy_len", run5, 7);
                end
            end
            run5 = 0;
        end
    end

    initial begin
        int waited;
        rst_n = 1'b0;
        x8    = 1'b1;
        x5    = 1'b1;
        #1;
        check("reset_data_out8", {24'd0, data_out8}, 32'd0);
        check("reset_flags8", {28'd0, dv8, perr8, ferr8, busy8}, 32'd0);
        check("reset_data_out5", {27'd0, data_out5}, 32'd0);
        check("reset_flags5", {28'd0, dv5, perr5, ferr5, busy5}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: idle then A5 with correct even parity
        idle(8, 5);
        send_frame(8, 8, 32'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(8, 3);
        // 2: 07 with wrong parity bit
        send_frame(8, 8, 32'h07, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(8, 3);
        // 3: 3C with stop bit 0, then long idle-high
        send_frame(8, 8, 32'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(8, 15);
        check("held_data_out8", {24'd0, data_out8}, 32'h3C);
        check("held_frame_err8", {31'd0, ferr8}, 32'd1);
        check("idle_busy8", {31'd0, busy8}, 32'd0);
        // 4: back-to-back 01 and FE, no idle gap
        send_frame(8, 8, 32'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8, 8, 32'hFE, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(8, 3);

        // 5: reset during data bit 4 of a frame (start + bits 0..3 already sent)
        drive_bit(8, 1'b0);
        drive_bit(8, 1'b1);
        drive_bit(8, 1'b0);
        drive_bit(8, 1'b1);
        drive_bit(8, 1'b0);
        drive_bit(8, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_data_out8", {24'd0, data_out8}, 32'd0);
        check("midreset_flags8", {28'd0, dv8, perr8, ferr8, busy8}, 32'd0);
        x8 = 1'b1;
        repeat (2) @(negedge clk);
        check("inreset_busy8", {31'd0, busy8}, 32'd0);
        rst_n = 1'b1;
        idle(8, 12);
        send_frame(8, 8, 32'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(8, 3);

        // 6: odd parity, 5-bit word 10110
        send_frame(5, 5, 32'h16, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(5, 2);
        send_frame(5, 5, 32'h16, 1'b1, 1'b1, 1'b1, 1'b0);

        waited = 0;
        while ((q8.size() != 0 || q5.size() != 0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        idle(5, 3);
        check("drain_q8", q8.size(), 32'd0);
        check("drain_q5", q5.size(), 32'd0);
        check("strobe_count8", strobes8, 32'd6);
        check("strobe_count5", strobes5, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
